// File: rtl/delta_qp_dec_pkg.sv
// Shared constants and state encoding for the delta-QP se(v) decoder.
package delta_qp_dec_pkg;

    localparam int DQP_W      = 6;
    localparam int MAX_PREFIX = 5;
    localparam int LEN_W      = 4;
    localparam int DQP_MIN    = -26;
    localparam int DQP_MAX    = 25;

    typedef enum logic [1:0] {
        S_PREFIX,
        S_SUFFIX,
        S_OUT
    } state_t;

endpackage

// File: rtl/delta_qp_map.sv
// Maps a 6-bit Exp-Golomb codeNum onto a signed delta QP.
// Results outside -26..+25 are clamped and flagged.
module delta_qp_map
    import delta_qp_dec_pkg::*;
#(
    parameter int DQP_W = delta_qp_dec_pkg::DQP_W
) (
    input  logic [5:0]              code_num,
    output logic signed [DQP_W-1:0] dqp,
    output logic                    err
);

    logic [5:0]        mag;
    logic signed [6:0] val;

    always_comb begin
        mag = '0;
        val = '0;
        err = 1'b0;
        // Odd k: (k+1)/2 equals (k>>1)+1. Even k: k>>1, negated.
        if (code_num[0]) begin
            mag = {1'b0, code_num[5:1]} + 6'd1;
            if (mag > 6'(DQP_MAX)) begin
                mag = 6'(DQP_MAX);
                err = 1'b1;
            end
            val = $signed({1'b0, mag});
        end else begin
            mag = {1'b0, code_num[5:1]};
            if (mag > 6'(-DQP_MIN)) begin
                mag = 6'(-DQP_MIN);
                err = 1'b1;
            end
            val = -$signed({1'b0, mag});
        end
        dqp = DQP_W'(val);
    end

endmodule

// File: rtl/delta_qp_dec.sv
// Bit-serial se(v) decoder for mb_qp_delta: counts the zero prefix, shifts
// in the suffix, then holds the mapped result until the downstream takes it.
module delta_qp_dec
    import delta_qp_dec_pkg::*;
#(
    parameter int DQP_W      = delta_qp_dec_pkg::DQP_W,
    parameter int MAX_PREFIX = delta_qp_dec_pkg::MAX_PREFIX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic signed [DQP_W-1:0] dqp,
    output logic [LEN_W-1:0]        dqp_len,
    output logic                    dqp_err,
    output logic                    dqp_valid,
    input  logic                    dqp_ready
);

    state_t                  state, state_n;
    logic [2:0]              zcnt, zcnt_n;
    logic [2:0]              rem, rem_n;
    logic [4:0]              suf, suf_n;
    logic [4:0]              suf_shift;
    logic [5:0]              code_num;
    logic signed [DQP_W-1:0] map_dqp, dqp_n;
    logic                    map_err, err_n;
    logic [LEN_W-1:0]        len_n;
    logic                    accept;

    assign bit_ready = (state != S_OUT);
    assign dqp_valid = (state == S_OUT);
    assign accept    = bit_valid && bit_ready;
    assign suf_shift = {suf[3:0], bit_in};
    // Map sees the suffix including the bit being accepted this cycle.
    assign code_num  = ((6'd1 << zcnt) - 6'd1) + {1'b0, suf_shift};

    delta_qp_map #(.DQP_W(DQP_W)) u_map (
        .code_num (code_num),
        .dqp      (map_dqp),
        .err      (map_err)
    );

    always_comb begin
        state_n = state;
        zcnt_n  = zcnt;
        rem_n   = rem;
        suf_n   = suf;
        dqp_n   = dqp;
        len_n   = dqp_len;
        err_n   = dqp_err;
        case (state)
            S_PREFIX: begin
                if (accept) begin
                    if (bit_in) begin
                        if (zcnt == 3'd0) begin
                            state_n = S_OUT;
                            dqp_n   = '0;
                            len_n   = LEN_W'(1);
                            err_n   = 1'b0;
                        end else begin
                            state_n = S_SUFFIX;
                            rem_n   = zcnt;
                            suf_n   = '0;
                        end
                    end else if (zcnt == 3'(MAX_PREFIX)) begin
                        state_n = S_OUT;
                        dqp_n   = '0;
                        len_n   = LEN_W'(MAX_PREFIX + 1);
                        err_n   = 1'b1;
                    end else begin
                        zcnt_n = zcnt + 3'd1;
                    end
                end
            end
            S_SUFFIX: begin
                if (accept) begin
                    suf_n = suf_shift;
                    rem_n = rem - 3'd1;
                    if (rem == 3'd1) begin
                        state_n = S_OUT;
                        dqp_n   = map_dqp;
                        err_n   = map_err;
                        len_n   = LEN_W'({zcnt, 1'b1});
                    end
                end
            end
            S_OUT: begin
                if (dqp_ready) begin
                    state_n = S_PREFIX;
                    zcnt_n  = '0;
                    suf_n   = '0;
                end
            end
            default: state_n = S_PREFIX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= S_PREFIX;
            zcnt    <= '0;
            rem     <= '0;
            suf     <= '0;
            dqp     <= '0;
            dqp_len <= '0;
            dqp_err <= 1'b0;
        end else begin
            state   <= state_n;
            zcnt    <= zcnt_n;
            rem     <= rem_n;
            suf     <= suf_n;
            dqp     <= dqp_n;
            dqp_len <= len_n;
            dqp_err <= err_n;
        end
    end

endmodule

// File: tb/tb_delta_qp_dec.sv
// Self-checking bench for delta_qp_dec: directed vector table, corner
// sequences and random codewords against an arithmetic Exp-Golomb model.
module tb_delta_qp_dec;

    logic              clk = 1'b0;
    logic              rst, clr, bit_in, bit_valid, dqp_ready;
    logic              bit_ready, dqp_err, dqp_valid;
    logic signed [5:0] dqp;
    logic [3:0]        dqp_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delta_qp_dec #(.DQP_W(6), .MAX_PREFIX(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .dqp       (dqp),
        .dqp_len   (dqp_len),
        .dqp_err   (dqp_err),
        .dqp_valid (dqp_valid),
        .dqp_ready (dqp_ready)
    );

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          gap;
        int          hold;
        int          edq;
        int          elen;
        int          eerr;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Codeword read as a binary number equals codeNum+1.
    function automatic void model(input logic [15:0] bits, input int n,
                                  output int dq, output int len, output int err);
        int z = 0;
        int k;
        while (z < n && bits[n-1-z] == 1'b0) z++;
        if (z > 5) begin
            dq = 0; len = 6; err = 1;
            return;
        end
        k   = int'(bits) - 1;
        len = n;
        err = 0;
        dq  = (k % 2 == 1) ? (k + 1) / 2 : -(k / 2);
        if (dq > 25)  begin dq = 25;  err = 1; end
        if (dq < -26) begin dq = -26; err = 1; end
    endfunction

    task automatic push_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic stream(input vec_t v, input string tag);
        logic b;
        for (int i = 0; i < v.n; i++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < v.gap; g++) begin
                bit_valid = 1'b0;
                @(posedge clk); #1;
            end
            check({tag, "_bit_ready"}, int'(bit_ready), 1);
            b = v.bits[v.n-1-i];
            push_bit(b);
            if (i < v.n - 1) check({tag, "_early_valid"}, int'(dqp_valid), 0);
        end
        check({tag, "_valid"}, int'(dqp_valid), 1);
        check({tag, "_dqp"}, int'(dqp), v.edq);
        check({tag, "_len"}, int'(dqp_len), v.elen);
        check({tag, "_err"}, int'(dqp_err), v.eerr);
        if (v.hold > 0) begin
            dqp_ready = 1'b0;
            for (int h = 0; h < v.hold; h++) begin
                bit_valid = 1'b1;
                bit_in    = 1'($urandom_range(1));
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, int'(dqp_valid), 1);
                check({tag, "_hold_ready"}, int'(bit_ready), 0);
                check({tag, "_hold_dqp"}, int'(dqp), v.edq);
                check({tag, "_hold_len"}, int'(dqp_len), v.elen);
                check({tag, "_hold_err"}, int'(dqp_err), v.eerr);
            end
            bit_valid = 1'b0;
            dqp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_released"}, int'(dqp_valid), 0);
        check({tag, "_ready_again"}, int'(bit_ready), 1);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1; clr = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; dqp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bit_ready", int'(bit_ready), 1);
        check("rst_valid", int'(dqp_valid), 0);
        check("rst_dqp", int'(dqp), 0);
        check("rst_len", int'(dqp_len), 0);
        check("rst_err", int'(dqp_err), 0);
        rst = 1'b0;

        //          bits              n   gap hold  dqp  len err
        tbl.push_back('{16'b1,            1,  0, 0,   0,  1, 0});
        tbl.push_back('{16'b010,          3,  0, 0,   1,  3, 0});
        tbl.push_back('{16'b011,          3,  0, 0,  -1,  3, 0});
        tbl.push_back('{16'b00111,        5,  0, 0,  -3,  5, 0});
        tbl.push_back('{16'b00000110010, 11,  0, 0,  25, 11, 0});
        tbl.push_back('{16'b00000110101, 11,  0, 0, -26, 11, 0});
        tbl.push_back('{16'b00000110100, 11,  0, 0,  25, 11, 1});
        tbl.push_back('{16'b00000111110, 11,  0, 0,  25, 11, 1});
        tbl.push_back('{16'b000000,       6,  0, 3,   0,  6, 1});
        tbl.push_back('{16'b1,            1,  0, 0,   0,  1, 0});
        tbl.push_back('{16'b010,          3,  0, 5,   1,  3, 0});
        tbl.push_back('{16'b0001011,      7,  0, 0,  -5,  7, 0});
        tbl.push_back('{16'b0001011,      7, 50, 0,  -5,  7, 0});
        foreach (tbl[i]) stream(tbl[i], $sformatf("vec%0d", i));

        // clr mid-codeword discards the prefix; its bit is not consumed.
        push_bit(1'b0); push_bit(1'b0); push_bit(1'b0); push_bit(1'b1);
        clr = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; bit_valid = 1'b0;
        check("clr_valid", int'(dqp_valid), 0);
        check("clr_bit_ready", int'(bit_ready), 1);
        stream('{16'b1, 1, 0, 0, 0, 1, 0}, "clr_next");

        // rst wins over a simultaneous handshake in S_OUT.
        push_bit(1'b1);
        check("out_valid", int'(dqp_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", int'(dqp_valid), 0);
        check("rst_out_len", int'(dqp_len), 0);
        check("rst_out_dqp", int'(dqp), 0);
        stream('{16'b011, 3, 0, 0, -1, 3, 0}, "rst_next");

        for (int r = 0; r < 40; r++) begin
            int z;
            z = int'($urandom_range(6));
            if (z == 6) begin
                rv.bits = '0;
                rv.n    = 6;
            end else begin
                rv.n    = 2 * z + 1;
                rv.bits = 16'((1 << z) | int'($urandom_range((1 << z) - 1)));
            end
            rv.gap  = ($urandom_range(1) == 1) ? 30 : 0;
            rv.hold = int'($urandom_range(2));
            model(rv.bits, rv.n, rv.edq, rv.elen, rv.eerr);
            stream(rv, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
